// File: rtl/mult_product_accumulator.sv
// mult_product_accumulator: sums unsigned product beats over a frame and
// presents the widened sum, beat count and sticky overflow for one
// valid/ready transfer.
// Optional build macro MULT_ACC_SATURATE_EN: when defined, the accumulator
// clamps at all-ones on carry-out instead of wrapping.
module mult_product_accumulator #(
  parameter int DWIDTH    = 72,
  parameter int ACC_GUARD = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DWIDTH-1:0]             in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DWIDTH+ACC_GUARD-1:0]   out_data,
  output logic [CNT_WIDTH-1:0]          out_count,
  output logic                          out_overflow
);

  localparam int AW = DWIDTH + ACC_GUARD;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [AW-1:0]         odata_q, odata_d;
  logic [CNT_WIDTH-1:0]  ocnt_q, ocnt_d;
  logic                  oovf_q, oovf_d;

  logic [AW:0]           sum_w;
  logic                  carry;
  logic [AW-1:0]         acc_nxt;
  logic [CNT_WIDTH-1:0]  cnt_inc;
  logic                  accept;

  // Handshake flags are pure state decodes so out_ready never reaches in_ready.
  assign in_ready     = (state_q == ACCUM);
  assign out_valid    = (state_q == HOLD);
  assign out_data     = odata_q;
  assign out_count    = ocnt_q;
  assign out_overflow = oovf_q;
  assign accept       = in_valid && in_ready;

  // Datapath: widened add with carry-out, saturating beat count.
  always_comb begin
    sum_w = {1'b0, acc_q} + {{(ACC_GUARD+1){1'b0}}, in_data};
    carry = sum_w[AW];
`ifdef MULT_ACC_SATURATE_EN
    // Once clamped the accumulator stays at all-ones for the rest of the frame.
    acc_nxt = (carry || ovf_q) ? {AW{1'b1}} : sum_w[AW-1:0];
`else
    acc_nxt = sum_w[AW-1:0];
`endif
    cnt_inc = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  end

  // Next-state: accumulate in ACCUM, latch result on last beat, hold until taken.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    odata_d = odata_q;
    ocnt_d  = ocnt_q;
    oovf_d  = oovf_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          if (in_last) begin
            odata_d = acc_nxt;
            ocnt_d  = cnt_inc;
            oovf_d  = ovf_q | carry;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = HOLD;
          end else begin
            acc_d = acc_nxt;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | carry;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      odata_q <= '0;
      ocnt_q  <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      odata_q <= odata_d;
      ocnt_q  <= ocnt_d;
      oovf_q  <= oovf_d;
    end
  end

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Self-checking bench for mult_product_accumulator. A second instance with
// ACC_GUARD=1 shares all inputs so the narrow-accumulator overflow behaviour
// is checked alongside the default build.
module tb_mult_product_accumulator;

  localparam logic [71:0] MAX72 = {72{1'b1}};
`ifdef MULT_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, in_valid, in_last, out_ready;
  logic [71:0] in_data;
  logic        in_ready, out_valid, out_overflow;
  logic [79:0] out_data;
  logic [7:0]  out_count;
  logic        b_in_ready, b_out_valid, b_out_overflow;
  logic [72:0] b_out_data;
  logic [7:0]  b_out_count;

  mult_product_accumulator dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .out_overflow(out_overflow));

  mult_product_accumulator #(.ACC_GUARD(1)) dut_g1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_data(b_out_data), .out_count(b_out_count),
    .out_overflow(b_out_overflow));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [71:0] fq[$];
  logic [79:0] e_data;
  logic [7:0]  e_cnt;
  logic        e_ovf;
  logic [72:0] e2_data;
  logic        e2_ovf;

  typedef struct {
    int              n;
    logic [3:0][71:0] d;
    logic [79:0]     xd;
    logic [7:0]      xc;
    logic            xo;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: exact frame sum in wide arithmetic, then range/count rules.
  function automatic void model();
    logic [127:0] s;
    s = '0;
    foreach (fq[i]) s += {56'd0, fq[i]};
    e_cnt   = (fq.size() > 255) ? 8'd255 : 8'(fq.size());
    e_ovf   = (s >> 80) != 0;
    e_data  = (SAT && e_ovf) ? {80{1'b1}} : s[79:0];
    e2_ovf  = (s >> 73) != 0;
    e2_data = (SAT && e2_ovf) ? {73{1'b1}} : s[72:0];
  endfunction

  function automatic logic [71:0] rnd72();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[71:0];
  endfunction

  // Present one beat (after optional idle cycles carrying junk) until accepted.
  task automatic send(input logic [71:0] d, input logic last, input int gap);
    int t;
    repeat (gap) begin
      in_valid = 1'b0; in_data = rnd72(); in_last = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b1; in_data = d; in_last = last;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    chk("in_ready_wait", in_ready, 1);
    @(posedge clk);
    fq.push_back(d);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    if (last) begin model(); fq.delete(); end
  endtask

  // Stall the sink for 'delay' cycles, then take the result and check it.
  task automatic get_result(input int delay);
    int t;
    out_ready = 1'b0;
    repeat (delay) begin
      @(negedge clk);
      chk("hold_stable", out_data, e_data);
    end
    out_ready = 1'b1;
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    chk("out_valid_wait", out_valid, 1);
    chk("out_data", out_data, e_data);
    chk("out_count", out_count, e_cnt);
    chk("out_overflow", out_overflow, e_ovf);
    chk("g1_out_data", b_out_data, e2_data);
    chk("g1_out_overflow", b_out_overflow, e2_ovf);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bubble_out_valid", out_valid, 0);
  endtask

  initial begin
    tbl[0] = '{3, {72'd0, 72'd7, 72'd5, 72'd3}, 80'd15, 8'd3, 1'b0};
    tbl[1] = '{1, {72'd0, 72'd0, 72'd0, MAX72}, {8'd0, MAX72}, 8'd1, 1'b0};
    tbl[2] = '{2, {72'd0, 72'd0, MAX72, MAX72}, {7'd0, MAX72, 1'b0}, 8'd2, 1'b0};
    tbl[3] = '{1, {72'd0, 72'd0, 72'd0, 72'd0}, 80'd0, 8'd1, 1'b0};
    tbl[4] = '{4, {72'd4, 72'd3, 72'd2, 72'd1}, 80'd10, 8'd4, 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_overflow", out_overflow, 0);
    chk("rst_in_ready", in_ready, 1);

    // 3,5,7 with sink ready: valid right after last, in_ready low one cycle.
    out_ready = 1'b1;
    send(72'd3, 1'b0, 0);
    send(72'd5, 1'b0, 0);
    send(72'd7, 1'b1, 0);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_in_ready", in_ready, 0);
    chk("t1_out_data", out_data, 15);
    chk("t1_out_count", out_count, 3);
    chk("t1_out_overflow", out_overflow, 0);
    @(negedge clk);
    chk("t1_in_ready_back", in_ready, 1);
    chk("t1_out_valid_drop", out_valid, 0);
    out_ready = 1'b0;

    // Table-driven frames.
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < tbl[i].n; j++)
        send(tbl[i].d[j], (j == tbl[i].n - 1), $urandom_range(0, 1));
      e_data = tbl[i].xd; e_cnt = tbl[i].xc; e_ovf = tbl[i].xo;
      get_result($urandom_range(0, 2));
    end

    // Three full-scale beats: wraps/clamps in the 73-bit instance.
    send(MAX72, 1'b0, 0);
    send(MAX72, 1'b0, 0);
    send(MAX72, 1'b1, 0);
    chk("g1_ovf_data", b_out_data, SAT ? {73{1'b1}} : ({1'b0, MAX72} - 73'd2));
    chk("g1_ovf_flag", b_out_overflow, 1);
    get_result(0);

    // Long backpressure with in_valid held high.
    send(72'd9, 1'b1, 0);
    in_valid = 1'b1; in_data = 72'd77; in_last = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 9);
      chk("bp_out_count", out_count, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_released", out_valid, 0);
    send(72'd4, 1'b1, 0);
    get_result(0);
    chk("bp_next_frame", e_data, 4);

    // Reset mid-frame discards the partial sum.
    send(72'd100, 1'b0, 0);
    send(72'd200, 1'b0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fq.delete();
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_out_count", out_count, 0);
    chk("mrst_out_overflow", out_overflow, 0);
    chk("mrst_in_ready", in_ready, 1);
    send(72'd1, 1'b1, 0);
    chk("mrst_frame_data", out_data, 1);
    chk("mrst_frame_count", out_count, 1);
    get_result(0);

    // Reset while a result is pending drops it.
    send(72'd5, 1'b1, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("hrst_out_valid", out_valid, 0);
    chk("hrst_out_data", out_data, 0);

    // 300-beat frame: count saturates, sum does not.
    for (int k = 0; k < 299; k++) send(72'd1, 1'b0, 0);
    send(72'd1, 1'b1, 0);
    chk("long_count", out_count, 255);
    chk("long_data", out_data, 300);
    get_result(1);

    // Randomized frames against the reference model.
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        logic [71:0] d;
        case ($urandom_range(0, 3))
          0: d = MAX72;
          1: d = 72'($urandom_range(0, 255));
          default: d = rnd72();
        endcase
        send(d, (j == len - 1), $urandom_range(0, 2));
      end
      get_result($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_product_accumulator.md
Name: mult_product_accumulator

Overview:
- Downstream consumer of the registered 72-bit product stream from the 36x36 multiplier stage.
- Sums unsigned products over a frame that ends on a beat with in_last, then presents the widened sum for one valid/ready transfer.
- Sits between the multiplier output register and any result sink; turns the multiplier into a dot-product / MAC engine.

Parameters:
- DWIDTH, 72, product width (2 x 36-bit operand width).
- ACC_GUARD, 8, guard bits added above DWIDTH in the accumulator.
- CNT_WIDTH, 8, width of the per-frame beat counter.

Ports:
- clk  input  1  single clock, all state on posedge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  DWIDTH  unsigned product.
- in_last  input  1  beat is last of frame; qualified by in_valid.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts result.
- out_data  output  DWIDTH+ACC_GUARD  frame sum.
- out_count  output  CNT_WIDTH  beats in frame, last beat included.
- out_overflow  output  1  sticky: sum exceeded accumulator range during frame.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: out_valid=0, out_data=0, out_count=0, out_overflow=0. Accumulator, counter and overflow flag are 0. State is ACCUM. in_ready=1 in the first cycle after reset deasserts.
- Accept: in_valid && in_ready at posedge. Result transfer: out_valid && out_ready at posedge.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - Non-last accept: acc <= acc + zero-extended in_data (mod 2^(DWIDTH+ACC_GUARD)); cnt <= cnt+1, saturating at 2^CNT_WIDTH-1; ovf <= ovf | carry-out.
  - Last accept: out_data <= acc + in_data, out_count <= saturated cnt+1, out_overflow <= ovf | carry. Then clear acc, cnt and ovf, and go to HOLD.
  - Latency: out_valid=1 in the cycle after the last beat is accepted.
- State HOLD:
  - in_ready=0, out_valid=1; out_data, out_count and out_overflow are held stable.
  - Result transfer -> ACCUM next cycle, out_valid=0. This gives a one-cycle bubble per frame.
  - Backpressure may last indefinitely; outputs do not change while out_ready=0.
- in_data and in_last are ignored when in_valid=0 or in_ready=0.
- Single-beat frame (in_last on the first beat): out_data = in_data, out_count = 1.
- Reset mid-frame discards the partial sum. Reset in HOLD drops the pending result (out_valid=0 next cycle).
- in_ready and out_valid are registered-state decodes only, with no combinational path from out_ready.

Optional Feature:
- Macro: MULT_ACC_SATURATE_EN.
- Defined: on any carry-out, acc clamps to 2^(DWIDTH+ACC_GUARD)-1 and stays clamped for the rest of the frame. out_overflow is still set.
- Undefined: acc wraps modulo 2^(DWIDTH+ACC_GUARD), and out_overflow flags the wrap.

Test Plan:
- Frame 3, 5, 7 with in_last on 7, out_ready=1 -> out_valid one cycle after the 7 beat; out_data=15, out_count=3, out_overflow=0. in_ready=0 for exactly one cycle.
- Single beat 2^72-1 with in_last -> out_data=2^72-1, out_count=1.
- ACC_GUARD=1, three beats of 2^72-1:
  - Macro undefined -> out_data=2^72-3, out_overflow=1.
  - MULT_ACC_SATURATE_EN defined -> out_data=2^73-1, out_overflow=1.
- Result pending with out_ready=0 for 10 cycles and in_valid=1 throughout -> in_ready=0, outputs stable, no beats accepted. After out_ready=1 for one cycle, the next frame 4 (last) gives out_data=4.
- Reset pulse after beats 100, 200 mid-frame, then frame 1 (last) -> out_data=1, out_count=1. All outputs 0 in the cycle after reset.
- CNT_WIDTH=8, 300-beat frame of value 1 -> out_count=255, out_data=300, out_overflow=0.
